// File: rtl/seg7_scan_drv.sv
// Scanned driver for an 8-digit common-anode seven-segment display, hex or raw-segment mode.
// Define SEG7_LZB_EN to blank leading zero digits in hex mode.

module seg7_slot (
  input  logic [3:0] nib,
  input  logic [7:0] raw,
  input  logic       mode,
  input  logic       raw_en,
  input  logic       lit,
  output logic [7:0] seg,
  output logic       on
);
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  always_comb begin
    seg = 8'hFF;
    on  = 1'b0;
    if (mode) begin
      if (raw_en) begin
        seg = raw;
        on  = 1'b1;
      end
    end else if (lit) begin
      seg = hex7(nib);
      on  = 1'b1;
    end
  end
endmodule

module seg7_scan_drv #(
  parameter int SCAN_DIV_W = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_data,
  input  logic        i_mode,
  input  logic        i_load,
  output logic        o_pend,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel
);
  localparam int NUM_DIG = 8;

  typedef struct packed {
    logic        mode;
    logic [31:0] data;
  } disp_t;

  logic [SCAN_DIV_W-1:0]       div_cnt;
  logic [2:0]                  dig, nxt_dig;
  disp_t                       pend, shd, src;
  logic                        pend_vld, tick, xfer;
  logic [NUM_DIG-1:0][7:0]     slot_seg;
  logic [NUM_DIG-1:0]          slot_on, lit;

  assign tick    = &div_cnt;
  assign xfer    = tick && (dig == 3'd7) && pend_vld;
  assign nxt_dig = dig + 3'd1;
  // Digit 0 of a new frame decodes the word being transferred on this same edge.
  assign src     = xfer ? pend : shd;
  assign o_pend  = pend_vld;

`ifdef SEG7_LZB_EN
  logic [2:0] msn;
  always_comb begin
    msn = 3'd0;
    for (int i = 0; i < NUM_DIG; i++)
      if (src.data[4*i +: 4] != 4'h0) msn = 3'(i);
  end
  for (genvar k = 0; k < NUM_DIG; k++) begin : g_lit
    assign lit[k] = (3'(k) <= msn);
  end
`else
  assign lit = '1;
`endif

  for (genvar k = 0; k < NUM_DIG; k++) begin : g_slot
    logic [7:0] raw;
    if (k < 4) begin : g_raw
      assign raw = src.data[8*k +: 8];
    end else begin : g_dark
      assign raw = 8'hFF;
    end
    seg7_slot u_slot (
      .nib    (src.data[4*k +: 4]),
      .raw    (raw),
      .mode   (src.mode),
      .raw_en (k < 4),
      .lit    (lit[k]),
      .seg    (slot_seg[k]),
      .on     (slot_on[k])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt  <= '0;
      dig      <= 3'd7;
      pend     <= '0;
      pend_vld <= 1'b0;
      shd      <= '0;
      o_seg    <= 8'hFF;
      o_sel    <= 8'hFF;
    end else begin
      div_cnt <= div_cnt + SCAN_DIV_W'(1);
      if (xfer) shd <= pend;
      // A load on the boundary edge replaces pend after the old word has moved out.
      if (i_load) begin
        pend     <= '{mode: i_mode, data: i_data};
        pend_vld <= 1'b1;
      end else if (xfer) begin
        pend_vld <= 1'b0;
      end
      if (tick) begin
        dig   <= nxt_dig;
        o_sel <= slot_on[nxt_dig] ? ~(8'd1 << nxt_dig) : 8'hFF;
        o_seg <= slot_seg[nxt_dig];
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv at SCAN_DIV_W=2 (one digit tick every 4 clocks).
module tb_seg7_scan_drv;
  logic        clk, rstn, i_mode, i_load, o_pend;
  logic [31:0] i_data;
  logic [7:0]  o_seg, o_sel;
  int total = 0, bad = 0;
  int d = 0;

  seg7_scan_drv #(.SCAN_DIV_W(2)) dut (
    .clk(clk), .rstn(rstn), .i_data(i_data), .i_mode(i_mode), .i_load(i_load),
    .o_pend(o_pend), .o_seg(o_seg), .o_sel(o_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task tick;
    repeat (4) @(negedge clk);
    d = (d + 1) % 8;
  endtask

  // Load one cycle after a tick, then advance to the next tick sample point.
  task load_mid(input logic [31:0] dat, input logic m);
    i_data = dat; i_mode = m; i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    repeat (3) @(negedge clk);
    d = (d + 1) % 8;
  endtask

  task test_reset;
    rstn = 1'b0; i_load = 1'b0; i_data = '0; i_mode = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (o_seg !== 8'hFF) begin bad++; $display("FAIL rst_seg got=%h exp=FF", o_seg); end
    total++; if (o_sel !== 8'hFF) begin bad++; $display("FAIL rst_sel got=%h exp=FF", o_sel); end
    total++; if (o_pend !== 1'b0) begin bad++; $display("FAIL rst_pend got=%b exp=0", o_pend); end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (o_sel !== 8'hFF) begin bad++; $display("FAIL pretick_sel got=%h exp=FF", o_sel); end
    total++; if (o_seg !== 8'hFF) begin bad++; $display("FAIL pretick_seg got=%h exp=FF", o_seg); end
    @(negedge clk);
    d = 0;
    total++; if (o_sel !== 8'hFE) begin bad++; $display("FAIL first_sel got=%h exp=FE", o_sel); end
    total++; if (o_seg !== 8'hC0) begin bad++; $display("FAIL first_seg got=%h exp=C0", o_seg); end
  endtask

  task test_idle;
    logic [7:0] es;
    for (int n = 0; n < 15; n++) begin
      tick();
      es = ~(8'd1 << d);
      total++; if (o_sel !== es) begin bad++; $display("FAIL idle_sel d=%0d got=%h exp=%h", d, o_sel, es); end
      total++; if (o_seg !== 8'hC0) begin bad++; $display("FAIL idle_seg d=%0d got=%h exp=C0", d, o_seg); end
    end
  endtask

  task test_hex_load;
    logic [7:0] hx [8];
    logic [7:0] es;
    hx = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    tick();
    load_mid(32'h89AB_CDEF, 1'b0);
    for (int k = 1; k < 8; k++) begin
      if (k > 1) tick();
      total++; if (o_pend !== 1'b1) begin bad++; $display("FAIL hex_pend d=%0d got=%b exp=1", d, o_pend); end
      total++; if (o_seg !== 8'hC0) begin bad++; $display("FAIL hex_old d=%0d got=%h exp=C0", d, o_seg); end
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      es = ~(8'd1 << k);
      if (k == 0) begin
        total++; if (o_pend !== 1'b0) begin bad++; $display("FAIL hex_pend_clr got=%b exp=0", o_pend); end
      end
      total++; if (o_seg !== hx[k]) begin bad++; $display("FAIL hex_seg d=%0d got=%h exp=%h", k, o_seg, hx[k]); end
      total++; if (o_sel !== es) begin bad++; $display("FAIL hex_sel d=%0d got=%h exp=%h", k, o_sel, es); end
    end
  endtask

  task test_newest_wins;
    tick();
    total++; if (o_seg !== 8'h8E) begin bad++; $display("FAIL nw_prev got=%h exp=8E", o_seg); end
    load_mid(32'h1, 1'b0);
    load_mid(32'h2, 1'b0);
    for (int k = 2; k < 8; k++) begin
      if (k > 2) tick();
      total++; if (o_pend !== 1'b1) begin bad++; $display("FAIL nw_pend d=%0d got=%b exp=1", d, o_pend); end
    end
    tick();
    total++; if (o_seg !== 8'hA4) begin bad++; $display("FAIL nw_d0 got=%h exp=A4", o_seg); end
    total++; if (o_pend !== 1'b0) begin bad++; $display("FAIL nw_pend_clr got=%b exp=0", o_pend); end
    for (int k = 1; k < 8; k++) begin
      tick();
      total++; if (o_seg !== 8'hC0) begin bad++; $display("FAIL nw_hi d=%0d got=%h exp=C0", d, o_seg); end
    end
  endtask

  task test_boundary_load;
    i_data = 32'h3; i_mode = 1'b0; i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    repeat (2) @(negedge clk);
    i_data = 32'h4; i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    d = 0;
    total++; if (o_seg !== 8'hB0) begin bad++; $display("FAIL bl_d0_old got=%h exp=B0", o_seg); end
    total++; if (o_pend !== 1'b1) begin bad++; $display("FAIL bl_pend_hold got=%b exp=1", o_pend); end
    for (int k = 1; k < 8; k++) begin
      tick();
      total++; if (o_pend !== 1'b1) begin bad++; $display("FAIL bl_pend d=%0d got=%b exp=1", d, o_pend); end
    end
    tick();
    total++; if (o_seg !== 8'h99) begin bad++; $display("FAIL bl_d0_new got=%h exp=99", o_seg); end
    total++; if (o_pend !== 1'b0) begin bad++; $display("FAIL bl_pend_clr got=%b exp=0", o_pend); end
    repeat (7) tick();
  endtask

  task test_raw;
    logic [7:0] rs [8];
    logic [7:0] rl [8];
    rs = '{8'h4F, 8'h5B, 8'h06, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    load_mid(32'h7F06_5B4F, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      total++; if (o_seg !== rs[k]) begin bad++; $display("FAIL raw_seg d=%0d got=%h exp=%h", k, o_seg, rs[k]); end
      total++; if (o_sel !== rl[k]) begin bad++; $display("FAIL raw_sel d=%0d got=%h exp=%h", k, o_sel, rl[k]); end
    end
  endtask

  task test_lzb;
    logic [7:0] ls [8];
    logic [7:0] ll [8];
`ifdef SEG7_LZB_EN
    ls = '{8'h92, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    ll = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    ls = '{8'h92, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    ll = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
`endif
    load_mid(32'h0000_00A5, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      total++; if (o_seg !== ls[k]) begin bad++; $display("FAIL lzb_seg d=%0d got=%h exp=%h", k, o_seg, ls[k]); end
      total++; if (o_sel !== ll[k]) begin bad++; $display("FAIL lzb_sel d=%0d got=%h exp=%h", k, o_sel, ll[k]); end
    end
  endtask

  task test_reset_mid;
    tick();
    load_mid(32'h1234_5678, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    total++; if (o_seg !== 8'hFF) begin bad++; $display("FAIL rm_seg got=%h exp=FF", o_seg); end
    total++; if (o_sel !== 8'hFF) begin bad++; $display("FAIL rm_sel got=%h exp=FF", o_sel); end
    total++; if (o_pend !== 1'b0) begin bad++; $display("FAIL rm_pend got=%b exp=0", o_pend); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (o_sel !== 8'hFF) begin bad++; $display("FAIL rm_pretick got=%h exp=FF", o_sel); end
    @(negedge clk);
    total++; if (o_seg !== 8'hC0) begin bad++; $display("FAIL rm_d0_seg got=%h exp=C0", o_seg); end
    total++; if (o_sel !== 8'hFE) begin bad++; $display("FAIL rm_d0_sel got=%h exp=FE", o_sel); end
    total++; if (o_pend !== 1'b0) begin bad++; $display("FAIL rm_d0_pend got=%b exp=0", o_pend); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_hex_load();
    test_newest_wins();
    test_boundary_load();
    test_raw();
    test_lzb();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
